m_unmapping: RTL

Inverse-direction fraction mapper for the ReMap log-domain datapath. It takes a mapped Mitchell fraction F, produced in the log domain after `m_mapping` and the log-domain add or subtract, and converts it back into a Mitchell fraction M for antilog reconstruction. It applies a fixed 4-region piecewise-linear shift-add correction selected by the top two bits of F. The block is a 2-stage valid/ready pipeline with saturation detection and a saturation event counter.

---
 rtl/m_unmapping.sv | 96 +++++++++
 1 files changed

// File: rtl/m_unmapping.sv
// Inverse fraction mapper: mapped fraction F -> Mitchell fraction M using a
// 4-region shift-add correction, 2-stage valid/ready pipeline, saturation counter.
module m_unmapping #(
   parameter int wl_m  = 31,
   parameter int wl_m2 = wl_m + 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [wl_m2-1:0] F,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [wl_m-1:0]  M,
   output logic             sat,
   output logic [15:0]      sat_count,
   input  logic             sat_clr
);

   localparam logic [wl_m2-1:0] K10 = {3'b000, 1'b1, {(wl_m2-4){1'b0}}};
   localparam logic [wl_m2-1:0] K11 = {2'b01, {(wl_m2-2){1'b0}}};

   typedef struct packed {
      logic [1:0]       r;
      logic [wl_m2-1:0] f;
      logic [wl_m2-1:0] sh;
      logic [wl_m2-1:0] k;
   } s1_t;

   logic [2:1]      vld_pipe;
   logic            e1, e2;
   s1_t             s1_d, s1_q;
   logic [wl_m2:0]  sum;
   logic            sat_d;
   logic [wl_m-1:0] m_d;
   logic            unused_lsb;

   assign e2        = !vld_pipe[2] || out_ready;
   assign e1        = !vld_pipe[1] || e2;
   assign in_ready  = e1;
   assign out_valid = vld_pipe[2];

   // Region 01 is identity: shifted operand and constant both stay zero.
   always_comb begin
      s1_d.r  = F[wl_m2-1 -: 2];
      s1_d.f  = F;
      s1_d.sh = '0;
      s1_d.k  = '0;
      unique case (F[wl_m2-1 -: 2])
         2'b00: s1_d.sh = F >> 2;
         2'b10: begin s1_d.sh = F >> 3; s1_d.k = K10; end
         2'b11: begin s1_d.sh = F >> 2; s1_d.k = K11; end
         default: ;
      endcase
   end

   // Upper regions subtract the shifted term, lower regions add it.
   always_comb begin
      if (s1_q.r[1])
         sum = {1'b0, s1_q.f} - {1'b0, s1_q.sh} + {1'b0, s1_q.k};
      else
         sum = {1'b0, s1_q.f} + {1'b0, s1_q.sh} + {1'b0, s1_q.k};
      sat_d = sum[wl_m2];
      m_d   = sat_d ? '1 : sum[wl_m2-1:3];
   end

   assign unused_lsb = ^sum[2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         M        <= '0;
         sat      <= 1'b0;
      end else begin
         if (e1) begin
            vld_pipe[1] <= in_valid;
            s1_q        <= s1_d;
         end
         if (e2) begin
            vld_pipe[2] <= vld_pipe[1];
            M           <= m_d;
            sat         <= sat_d;
         end
      end
   end

   // Clear beats a same-cycle increment; counter sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst || sat_clr)
         sat_count <= '0;
      else if (out_valid && out_ready && sat && sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end

endmodule
